mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: TIMEOUT, 8'd255, number of WAIT cycles without dm_ack before the access is aborted.
REQ-002 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-low.
REQ-004 MemRead  input  1  load in MEM stage.
REQ-005 MemWrite  input  1  store in MEM stage.
REQ-006 LoadCtrl  input  1  0 = word load (lw), 1 = signed byte load (lb).
REQ-007 StoreCtrl  input  1  0 = word store (sw), 1 = byte store (sb).
REQ-008 alu_out  input  32  effective byte address.
REQ-009 rtData  input  32  store data.
REQ-010 dm_ack  input  1  memory completion strobe; sampled only in WAIT.
REQ-011 dm_rdata  input  32  memory read word; valid with dm_ack.
REQ-012 dm_req, dm_we  output  1 each  registered request and write enable.
REQ-013 dm_addr  output  32  registered word address (alu_out with bits [1:0] forced to 0).
REQ-014 dm_wdata  output  32  registered write data.
REQ-015 dm_be  output  4  registered byte enables; bit i covers bits [8i+7:8i].
REQ-016 dmOut  output  32  formatted load result; feeds the MEM/WB register.
REQ-017 stall  output  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-018 misalign  output  1  combinational; word access with alu_out[1:0] != 0.
REQ-019 dm_err  output  1  sticky timeout flag.

Function
REQ-020 FSM states are IDLE, WAIT and DONE; encoding is free.
REQ-021 access = MemRead | MemWrite; when both are high, the access is a store and the read is ignored.
REQ-022 misalign = IDLE & access & word size & alu_out[1:0] != 0; a misaligned access issues no request, does not assert stall, and leaves dmOut unchanged.
REQ-023 IDLE, access & !misalign: stall = 1; on the next edge, go to WAIT and register dm_req = 1, dm_we = MemWrite, dm_addr, dm_wdata and dm_be.
REQ-024 Word store: dm_wdata = rtData, dm_be = 4'b1111.
REQ-025 Byte store: dm_wdata = {4{rtData[7:0]}}, dm_be = 4'b0001 << alu_out[1:0].
REQ-026 Any load: dm_be = 4'b1111, dm_wdata = 0.
REQ-027 WAIT: stall = 1; dm_* outputs hold; a wait counter increments each cycle.
REQ-028 WAIT & dm_ack: on that edge, dm_req <= 0 and dm_we <= 0, and the FSM goes to DONE; on a load, dmOut <= formatted dm_rdata.
REQ-029 Load formatting, word: dmOut = dm_rdata.
REQ-030 Load formatting, byte: select lane alu_out[1:0] (lane 0 = [7:0], little-endian) and sign-extend it to 32 bits.
REQ-031 WAIT, counter == TIMEOUT-1 and no dm_ack: on that edge, drop dm_req, set dm_err, set dmOut <= 0 on a load, and go to DONE.
REQ-032 dm_ack arriving on the same cycle as the timeout takes priority: normal completion, dm_err unchanged.
REQ-033 DONE: stall = 0, so the pipeline advances and MEM/WB captures dmOut; the FSM goes unconditionally to IDLE on the next edge.
REQ-034 Minimum access latency is 2 stalled cycles (IDLE plus one WAIT), with dm_ack in the first WAIT cycle.
REQ-035 A back-to-back access entering during DONE is started from IDLE on the following cycle.
REQ-036 dmOut holds its value until the next completed or timed-out load; stores never modify dmOut.
REQ-037 dm_ack outside WAIT is ignored.
REQ-038 No access in IDLE: stall = 0 and all outputs hold.

Reset
REQ-039 clr low, at any time including mid-WAIT, immediately forces: state IDLE; dm_req, dm_we, dm_addr, dm_wdata, dm_be, dmOut, dm_err and the wait counter to 0.
REQ-040 stall and misalign evaluate to 0 while clr is low.
REQ-041 A request aborted by reset is not retried.

Verification
REQ-042 lw at 0x100, dm_ack in the first WAIT cycle with dm_rdata = 0xDEADBEEF -> stall high 2 cycles; dm_addr = 0x100, dm_be = 4'hF; dmOut = 0xDEADBEEF in DONE.
REQ-043 lb at 0x103, dm_rdata = 0x80112233 -> dmOut = 0xFFFFFF80; lb at 0x101 -> dmOut = 0x00000022.
REQ-044 sb at 0x202, rtData = 0x000000A5, dm_ack after 3 WAIT cycles -> dm_we = 1, dm_be = 4'b0100, dm_wdata = 0xA5A5A5A5, stall high 4 cycles, dmOut unchanged.
REQ-045 sw at 0x006 -> misalign = 1, stall = 0, dm_req never rises.
REQ-046 lw with no dm_ack, TIMEOUT = 4 -> dm_req drops after 4 WAIT cycles; dm_err = 1, dmOut = 0, stall falls in DONE.
REQ-047 clr pulsed low in the 2nd WAIT cycle -> dm_req and stall drop at once; after release with no access, state is IDLE and no request is reissued.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MEM-stage data memory access FSM with byte/word formatting, stall generation and timeout
module mem_access #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        LoadCtrl,
   input  logic        StoreCtrl,
   input  logic [31:0] alu_out,
   input  logic [31:0] rtData,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_be,
   output logic [31:0] dmOut,
   output logic        stall,
   output logic        misalign,
   output logic        dm_err
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        req_q, we_q, err_q, ld_q, lb_q;
   logic [1:0]  lane_q;
   logic [31:0] addr_q, wdata_q, dmout_q;
   logic [3:0]  be_q;
   logic        access, store, word, start;
   logic [31:0] wdata_d, fmt_d;
   logic [3:0]  be_d;
   logic [7:0]  lane_byte;
   // decode the request, request payload and load formatting; a store wins over a simultaneous load
   always_comb begin
      access    = MemRead | MemWrite;
      store     = MemWrite;
      word      = store ? !StoreCtrl : !LoadCtrl;
      misalign  = clr & (state_q == IDLE) & access & word & (|alu_out[1:0]);
      start     = (state_q == IDLE) & access & !misalign;
      stall     = clr & (start | (state_q == WAIT));
      wdata_d   = !store ? 32'd0 : word ? rtData : {4{rtData[7:0]}};
      be_d      = (!store | word) ? 4'hF : 4'b0001 << alu_out[1:0];
      lane_byte = dm_rdata[{lane_q, 3'b000} +: 8];
      fmt_d     = lb_q ? {{24{lane_byte[7]}}, lane_byte} : dm_rdata;
   end
   // access FSM with registered memory-side outputs; the load kind and lane are captured at issue
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         ld_q    <= 1'b0;
         lb_q    <= 1'b0;
         lane_q  <= 2'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         dmout_q <= 32'd0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_q <= WAIT;
               cnt_q   <= 8'd0;
               req_q   <= 1'b1;
               we_q    <= store;
               addr_q  <= {alu_out[31:2], 2'b00};
               wdata_q <= wdata_d;
               be_q    <= be_d;
               ld_q    <= !store;
               lb_q    <= !store & LoadCtrl;
               lane_q  <= alu_out[1:0];
            end
            WAIT: if (dm_ack) begin
               state_q <= DONE;
               req_q   <= 1'b0;
               we_q    <= 1'b0;
               if (ld_q) dmout_q <= fmt_d;
            end else if (cnt_q == TIMEOUT - 8'd1) begin
               state_q <= DONE;
               req_q   <= 1'b0;
               we_q    <= 1'b0;
               err_q   <= 1'b1;
               if (ld_q) dmout_q <= 32'd0;
            end else begin
               cnt_q <= cnt_q + 8'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign dm_req   = req_q;
   assign dm_we    = we_q;
   assign dm_addr  = addr_q;
   assign dm_wdata = wdata_q;
   assign dm_be    = be_q;
   assign dmOut    = dmout_q;
   assign dm_err   = err_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and randomized accesses checked against a transaction-level model
module tb_mem_access;
   localparam int T = 4;
   logic        clk = 1'b0;
   logic        clr;
   logic        MemRead, MemWrite, LoadCtrl, StoreCtrl, dm_ack;
   logic [31:0] alu_out, rtData, dm_rdata;
   logic        dm_req, dm_we, stall, misalign, dm_err;
   logic [31:0] dm_addr, dm_wdata, dmOut;
   logic [3:0]  dm_be;
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_dmout = 32'd0;
   logic        exp_err = 1'b0;

   mem_access #(.TIMEOUT(8'(T))) dut (
      .clk(clk), .clr(clr), .MemRead(MemRead), .MemWrite(MemWrite),
      .LoadCtrl(LoadCtrl), .StoreCtrl(StoreCtrl), .alu_out(alu_out), .rtData(rtData),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_req(dm_req), .dm_we(dm_we),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dmOut(dmOut),
      .stall(stall), .misalign(misalign), .dm_err(dm_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one full access; ack_at is the zero-based WAIT cycle carrying dm_ack (>= T means never)
   task automatic access(input logic mr, input logic mw, input logic lc, input logic sc,
                         input logic [31:0] addr, input logic [31:0] data,
                         input int ack_at, input logic [31:0] rdata);
      logic store, word, mis, done, to;
      int stalls, w;
      logic [7:0] b;
      store = mw;
      word  = store ? !sc : !lc;
      mis   = word && addr[1:0] != 2'd0;
      @(negedge clk);
      MemRead = mr; MemWrite = mw; LoadCtrl = lc; StoreCtrl = sc;
      alu_out = addr; rtData = data; dm_ack = 1'b0; dm_rdata = $urandom;
      #1;
      chk("misalign", misalign, mis);
      chk("stall_idle", stall, !mis);
      if (mis) begin
         @(posedge clk); #1;
         chk("mis_no_req", dm_req, 0);
         chk("mis_dmout", dmOut, exp_dmout);
      end else begin
         stalls = 1;
         @(posedge clk); #1;
         chk("req", dm_req, 1);
         chk("we", dm_we, store);
         chk("addr", dm_addr, addr & 32'hFFFF_FFFC);
         chk("be", dm_be, (store && !word) ? 32'(1 << addr[1:0]) : 32'hF);
         chk("wdata", dm_wdata, !store ? 32'd0 : word ? data : data[7:0] * 32'h0101_0101);
         done = 1'b0; to = 1'b0; w = 0;
         while (!done) begin
            @(negedge clk);
            dm_ack   = (w == ack_at);
            dm_rdata = (w == ack_at) ? rdata : $urandom;
            #1;
            chk("stall_wait", stall, 1);
            stalls++;
            @(posedge clk); #1;
            if (w == ack_at) done = 1'b1;
            else if (w == T - 1) begin done = 1'b1; to = 1'b1; end
            w++;
            if (!done) chk("req_hold", dm_req, 1);
         end
         if (to) begin
            exp_err = 1'b1;
            if (!store) exp_dmout = 32'd0;
         end else if (!store) begin
            b = 8'(rdata >> (8 * addr[1:0]));
            exp_dmout = lc ? 32'(int'($signed(b))) : rdata;
         end
         chk("stall_done", stall, 0);
         chk("req_done", dm_req, 0);
         chk("we_done", dm_we, 0);
         chk("err", dm_err, exp_err);
         chk("dmout", dmOut, exp_dmout);
         chk("stall_cycles", 32'(stalls), to ? 32'(T + 1) : 32'(ack_at + 2));
      end
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0; dm_ack = 1'b1;
      #1;
      chk("stall_after", stall, 0);
      @(posedge clk); #1;
      chk("idle_req", dm_req, 0);
      chk("idle_dmout", dmOut, exp_dmout);
      dm_ack = 1'b0;
   endtask

   initial begin
      clr = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; LoadCtrl = 1'b0; StoreCtrl = 1'b0;
      alu_out = 32'd0; rtData = 32'd0; dm_ack = 1'b0; dm_rdata = 32'd0;
      #1;
      chk("rst_req", dm_req, 0);
      chk("rst_dmout", dmOut, 0);
      chk("rst_err", dm_err, 0);
      chk("rst_stall", stall, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); clr = 1'b1;
      access(1, 0, 0, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
      chk("lw100", dmOut, 32'hDEADBEEF);
      access(1, 0, 1, 0, 32'h103, 32'h0, 0, 32'h80112233);
      chk("lb103", dmOut, 32'hFFFFFF80);
      access(1, 0, 1, 0, 32'h101, 32'h0, 1, 32'h80112233);
      chk("lb101", dmOut, 32'h00000022);
      access(0, 1, 0, 1, 32'h202, 32'hA5, 2, 32'h12345678);
      chk("sb_keeps_dmout", dmOut, 32'h00000022);
      access(0, 1, 0, 0, 32'h006, 32'h11, 0, 32'h0);
      access(1, 1, 1, 0, 32'h008, 32'hCAFEF00D, 0, 32'h55555555);
      access(1, 0, 0, 0, 32'h040, 32'h0, T - 1, 32'h0BADCAFE);
      chk("ack_at_timeout_no_err", dm_err, 0);
      access(1, 0, 0, 0, 32'h044, 32'h0, 9, 32'h0);
      chk("timeout_err", dm_err, 1);
      chk("timeout_dmout", dmOut, 0);
      // reset in the second WAIT cycle
      @(negedge clk);
      MemRead = 1'b1; LoadCtrl = 1'b0; alu_out = 32'h300;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_req", dm_req, 1);
      #2 clr = 1'b0;
      #1;
      chk("rst_mid_req", dm_req, 0);
      chk("rst_mid_stall", stall, 0);
      chk("rst_mid_mis", misalign, 0);
      chk("rst_mid_err", dm_err, 0);
      chk("rst_mid_addr", dm_addr, 0);
      exp_dmout = 32'd0; exp_err = 1'b0;
      @(negedge clk); MemRead = 1'b0; clr = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("post_rst_req", dm_req, 0);
         chk("post_rst_stall", stall, 0);
      end
      for (int i = 0; i < 40; i++) begin
         logic r, wr;
         logic [31:0] a;
         r  = 1'($urandom);
         wr = r ? 1'($urandom) : 1'b1;
         a  = $urandom;
         if ($urandom_range(0, 2) != 0) a[1:0] = 2'd0;
         access(r, wr, 1'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 5), $urandom);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
